// File: rtl/fp_mul_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_result_fifo
// Purpose  : Result stage behind the single-precision FP multiplier. Accepts
//            product words with overflow/underflow flags over a valid/ready
//            handshake. Optionally applies IEEE-754 exception fix-up, then
//            buffers entries in a small FIFO that feeds the FPU result bus.
//            Also keeps sticky exception status and a saturating counter of
//            overflow events.
// Options  : `define FP_FIXUP_EN  -> overflow entries are stored as +/-inf and
//                                   underflow entries as +/-zero. When the
//                                   macro is undefined, in_result is stored
//                                   unchanged.
// Ports    : clk, rst_n               clock, async active-low reset
//            in_valid/in_ready        producer handshake (ready = count<DEPTH)
//            in_result/in_overflow/in_underflow  product word and flags
//            out_valid/out_ready      consumer handshake (valid = count!=0)
//            out_data/out_flags       registered FIFO head {ovf, udf}
//            count                    current occupancy
//            sticky_ovf/sticky_udf    sticky status, cleared by clr_sticky
//            ovf_count                saturating overflow-event counter
// Revision : 1.0 - initial release
// ============================================================================
module fp_mul_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_result,
    input  logic                     in_overflow,
    input  logic                     in_underflow,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [1:0]               out_flags,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     sticky_ovf,
    output logic                     sticky_udf,
    input  logic                     clr_sticky,
    output logic [CNT_W-1:0]         ovf_count
);

    localparam int                C_AW        = $clog2(DEPTH);
    localparam int                C_CW        = C_AW + 1;
    localparam logic [C_CW-1:0]   C_DEPTH     = C_CW'(DEPTH);
    localparam logic [C_CW-1:0]   C_CNT_ONE   = C_CW'(1);
    localparam logic [C_AW-1:0]   C_PTR_ONE   = C_AW'(1);
    localparam logic [CNT_W-1:0]  C_OVF_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  C_OVF_ONE   = CNT_W'(1);

    // Storage: each entry is {data[31:0], ovf, udf}
    logic [33:0]       mem_q [DEPTH];
    logic [C_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [C_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [C_CW-1:0]   count_q,  count_d;
    logic [31:0]       head_data_q,  head_data_d;
    logic [1:0]        head_flags_q, head_flags_d;
    logic              sticky_ovf_q, sticky_ovf_d;
    logic              sticky_udf_q, sticky_udf_d;
    logic [CNT_W-1:0]  ovf_cnt_q,    ovf_cnt_d;

    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_entry_data;
    logic [1:0]        w_entry_flags;

    assign in_ready  = (count_q < C_DEPTH);
    assign out_valid = (count_q != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Entry formation. Overflow dominates when both flags are raised, so the
    // stored flag pair is never 2'b11.
    always_comb begin
        w_entry_flags = 2'b00;
        if (in_overflow) begin
            w_entry_flags = 2'b10;
        end else if (in_underflow) begin
            w_entry_flags = 2'b01;
        end
`ifdef FP_FIXUP_EN
        if (in_overflow) begin
            w_entry_data = {in_result[31], 8'hFF, 23'h0};
        end else if (in_underflow) begin
            w_entry_data = {in_result[31], 31'h0};
        end else begin
            w_entry_data = in_result;
        end
`else
        w_entry_data = in_result;
`endif
    end

    // Next-state for pointers, occupancy and status. DEPTH is a power of two,
    // so pointer wrap is the natural rollover of C_AW-bit counters.
    always_comb begin
        wr_ptr_d = w_push ? wr_ptr_q + C_PTR_ONE : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + C_PTR_ONE : rd_ptr_q;

        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CNT_ONE;
            2'b01:   count_d = count_q - C_CNT_ONE;
            default: count_d = count_q;
        endcase

        // The output register tracks the head of the next cycle. When the
        // new read pointer lands on the slot being written this cycle, the
        // FIFO was (or became) empty and the incoming entry is the new head;
        // memory does not hold it yet. When the FIFO goes empty the last
        // head is left in place.
        head_data_d  = head_data_q;
        head_flags_d = head_flags_q;
        if ((count_d != '0) && (w_push || w_pop)) begin
            if (w_push && (rd_ptr_d == wr_ptr_q)) begin
                head_data_d  = w_entry_data;
                head_flags_d = w_entry_flags;
            end else begin
                head_data_d  = mem_q[rd_ptr_d][33:2];
                head_flags_d = mem_q[rd_ptr_d][1:0];
            end
        end

        // A set in the same cycle as a clear takes precedence.
        sticky_ovf_d = sticky_ovf_q;
        if (w_push && w_entry_flags[1]) begin
            sticky_ovf_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf_d = 1'b0;
        end

        sticky_udf_d = sticky_udf_q;
        if (w_push && w_entry_flags[0]) begin
            sticky_udf_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_udf_d = 1'b0;
        end

        ovf_cnt_d = ovf_cnt_q;
        if (w_push && w_entry_flags[1] && (ovf_cnt_q != C_OVF_MAX)) begin
            ovf_cnt_d = ovf_cnt_q + C_OVF_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_data_q  <= '0;
            head_flags_q <= '0;
            sticky_ovf_q <= 1'b0;
            sticky_udf_q <= 1'b0;
            ovf_cnt_q    <= '0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= {w_entry_data, w_entry_flags};
            end
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_data_q  <= head_data_d;
            head_flags_q <= head_flags_d;
            sticky_ovf_q <= sticky_ovf_d;
            sticky_udf_q <= sticky_udf_d;
            ovf_cnt_q    <= ovf_cnt_d;
        end
    end

    assign out_data   = head_data_q;
    assign out_flags  = head_flags_q;
    assign count      = count_q;
    assign sticky_ovf = sticky_ovf_q;
    assign sticky_udf = sticky_udf_q;
    assign ovf_count  = ovf_cnt_q;

endmodule
`default_nettype wire
